// File: rtl/vcdemux_buf.sv
`default_nettype none
// ============================================================================
// Module      : vcdemux_buf
// Description : Receive end of a 2-VC credit-based link. Steers each incoming
//               flit by its VC tag into one of two show-ahead FIFOs, exposes
//               the FIFO heads and returns one registered credit per pop.
// Revision    : 1.0  initial release
// ============================================================================
module vcdemux_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              ivalid,
    input  logic [DATA_W-1:0] idata,
    input  logic              ivch,
    output logic              ovalid0,
    output logic [DATA_W-1:0] odata0,
    input  logic              ideq0,
    output logic              ovalid1,
    output logic [DATA_W-1:0] odata1,
    input  logic              ideq1,
    output logic [1:0]        ocredit,
    output logic [PTR_W:0]    ocnt0,
    output logic [PTR_W:0]    ocnt1,
    output logic              overflow
);

    localparam logic [PTR_W:0] c_FULL = (PTR_W+1)'(DEPTH);

    logic [1:0]              deq_req;
    logic [1:0]              vc_valid;
    logic [1:0]              vc_pop;
    logic [1:0]              vc_ovf;
    logic [1:0][DATA_W-1:0]  vc_head;
    logic [1:0][PTR_W:0]     vc_cnt;

    logic [1:0]              credit_q;
    logic                    overflow_q;

    assign deq_req = {ideq1, ideq0};

    for (genvar n = 0; n < 2; n++) begin : g_vc
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
        logic [PTR_W:0]    cnt_q, cnt_d;
        logic              wr_req;
        logic              wr_ok;
        logic              pop;

        assign wr_req = ivalid && (ivch == 1'(n));
        assign pop    = deq_req[n] && (cnt_q != '0);
        // A full FIFO still accepts when its head leaves in the same cycle.
        assign wr_ok  = wr_req && ((cnt_q != c_FULL) || pop);

        // Next-state pointers and occupancy from the accepted write and the pop.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        // Pointer and occupancy registers.
        always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Flit storage; contents are don't-care until written, so no reset.
        always_ff @(posedge clk) begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= idata;
            end
        end

        assign vc_valid[n] = (cnt_q != '0);
        assign vc_head[n]  = vc_valid[n] ? mem_q[rd_ptr_q] : '0;
        assign vc_pop[n]   = pop;
        assign vc_ovf[n]   = wr_req && !wr_ok;
        assign vc_cnt[n]   = cnt_q;
    end

    // One-cycle credit pulse per pop, and the sticky dropped-flit flag.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            credit_q   <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            credit_q   <= vc_pop;
            overflow_q <= overflow_q | (|vc_ovf);
        end
    end

    assign ovalid0  = vc_valid[0];
    assign odata0   = vc_head[0];
    assign ocnt0    = vc_cnt[0];
    assign ovalid1  = vc_valid[1];
    assign odata1   = vc_head[1];
    assign ocnt1    = vc_cnt[1];
    assign ocredit  = credit_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire
